calc_engine: RTL and testbench
==============================

Name: calc_engine

Overview:
- Parametrised keypad calculator core. Consumes decoded key codes from the keyboard front end and builds two signed decimal operands of up to DIGITS digits each.
- Performs add, subtract or multiply and presents a range-checked signed result to the display driver.
- Successor to the fixed 3-digit operator block:
  - variable-length entry with optional sign keys;
  - explicit key strobe and result-valid handshake;
  - clear key;
  - overflow flag instead of LED pattern.

Parameters:
- DIGITS, 3, maximum decimal digits per operand; MAXVAL = 10**DIGITS-1.
- W, 11, signed operand/result width; must satisfy 2**(W-1)-1 >= MAXVAL.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0-9 digit, 10 plus, 11 minus, 12 times, 14 enter, 15 clear; 13 ignored
- result  out  W  signed two's-complement result
- result_valid  out  1  one-cycle pulse when result updates
- overflow  out  1  last operation out of range
- busy  out  1  high in EXEC/MUL; keys other than clear ignored

Behaviour:
- Reset values:
  - rst returns the FSM to SIGN1.
  - result=0, result_valid=0, overflow=0, busy=0; operands, signs, digit count and operator all 0.
  - rst wins over key_valid and aborts the multiplier.
- Key handling: keys act only on cycles with key_valid=1; one key per strobe.
- SIGN1:
  - 10 -> neg1=0, go DIG1.
  - 11 -> neg1=1, go DIG1.
  - digit d -> op1=d, cnt=1, go DIG1.
  - others ignored.
- DIG1:
  - digit with cnt<DIGITS -> op1=op1*10+d, cnt++.
  - digit with cnt==DIGITS -> ignored.
  - 10/11/12 -> latch operator ADD/SUB/MUL, cnt=0, go SIGN2.
  - 14 -> go OP.
- OP: 10/11/12 -> latch operator, go SIGN2; others ignored.
- SIGN2 and DIG2: mirror SIGN1/DIG1 for op2/neg2, except:
  - in DIG2, operator keys are ignored;
  - 14 -> go EXEC.
  - Enter in SIGN2 also goes to EXEC, with op2=0.
- EXEC (one cycle, busy=1):
  - Apply signs.
  - ADD/SUB: compute in W+1 bits, register result, go DONE.
  - MUL: pulse mul start, go MUL.
- MUL (busy=1): wait for mul_done; check the 2W-bit product; go DONE.
- Range check: if the signed value is >MAXVAL or <-MAXVAL -> result=0, overflow=1; else result=value, overflow=0.
- DONE:
  - result_valid=1 for exactly the cycle after the result register loads.
  - result holds until the next result.
  - A digit or sign key processes as in SIGN1, which starts a new operation and clears overflow.
  - 14 and operator keys are ignored.
- Clear (15), any state:
  - FSM -> SIGN1; operands, signs and count cleared; multiplier aborted; overflow cleared.
  - result held; no result_valid.
- Latency: register edge accepting enter = t.
  - ADD/SUB: result and result_valid visible after edge t+2.
  - MUL: visible after edge t+W+3. The multiplier takes exactly W cycles from start to done.
- Keys during busy (except clear) are dropped, not queued.
- Operand magnitudes never exceed MAXVAL; no truncation is possible in entry.

Optional Feature:
- Macro CALC_ECHO_EN.
- Defined:
  - during SIGN*/DIG* states, result continuously shows the signed value of the operand being entered (sign applied);
  - result_valid is not pulsed for echo updates;
  - the computed result replaces the echo at DONE.
- Undefined: result changes only on computation; behaviour is otherwise identical.

Decomposition:
- Package calc_pkg:
  - key code localparams (KEY_PLUS=10, KEY_MINUS=11, KEY_TIMES=12, KEY_ENTER=14, KEY_CLEAR=15);
  - FSM state encoding (SIGN1, DIG1, OP, SIGN2, DIG2, EXEC, MUL, DONE);
  - operator encoding (ADD=0, SUB=1, MUL=2).
- Sub-module seq_mult, parameter W:
  - signed radix-2 shift-add multiplier;
  - ports clk, rst, abort, start, a[W-1:0], b[W-1:0], prod[2W-1:0], done;
  - done is a one-cycle pulse W cycles after start.

Test Plan (DIGITS=3, W=11):
- Keys 1,2,3,+,4,5,6,enter -> result=579, result_valid one pulse 2 cycles after enter, overflow=0.
- Keys -,1,2,x,3,0,enter -> busy high 12 cycles, result=-360 at t+14, one result_valid.
- Keys 9,9,9,+,9,9,9,enter -> result=0, overflow=1; next key 5 -> overflow=0.
- Keys 1,2,3,4,-,-,2,3,enter -> 4th digit ignored, result=123-(-23)=146; also 5,0,x,2,0,enter -> overflow=1.
- Clear during MUL -> busy=0 next cycle, no result_valid, prior result held; rst mid-entry -> all outputs 0, state SIGN1.
- CALC_ECHO_EN defined: keys -,4,2 -> result shows -4 then -42, result_valid stays 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator core: key codes, FSM states and operators.
package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_TIMES = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd14;
  localparam logic [3:0] KEY_CLEAR = 4'd15;

  typedef enum logic [2:0] {
    ST_SIGN1 = 3'd0,
    ST_DIG1  = 3'd1,
    ST_OP    = 3'd2,
    ST_SIGN2 = 3'd3,
    ST_DIG2  = 3'd4,
    ST_EXEC  = 3'd5,
    ST_MUL   = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  // Map an operator key onto the operator it selects.
  function automatic op_e key_to_op(input logic [3:0] k);
    case (k)
      KEY_MINUS: return OP_SUB;
      KEY_TIMES: return OP_MUL;
      default:   return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_engine_mult.sv
// Signed radix-2 shift-add multiplier; done pulses W cycles after start.
module seq_mult #(
  parameter int unsigned W = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           abort,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           done
);

  localparam int unsigned IW = $clog2(W);

  logic [2*W-1:0] acc_q, mcand_q, a_ext, addend;
  logic [W-1:0]   mplier_q;
  logic [IW-1:0]  idx_q;
  logic           run_q, done_q;

  assign a_ext  = {{W{a[W-1]}}, a};
  // The multiplier MSB carries negative weight, so its partial product is subtracted.
  assign addend = (idx_q == IW'(W - 1)) ? -mcand_q : mcand_q;

  // Bit 0 is consumed on the start edge, the remaining W-1 bits on following edges.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      idx_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= b[0] ? a_ext : '0;
      mcand_q  <= a_ext << 1;
      mplier_q <= b >> 1;
      idx_q    <= IW'(1);
      run_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (run_q) begin
        if (mplier_q[0]) acc_q <= acc_q + addend;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        idx_q    <= idx_q + IW'(1);
        if (idx_q == IW'(W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign prod = acc_q;
  assign done = done_q;

endmodule

// File: rtl/calc_engine.sv
// Keypad calculator core: signed operand entry, add/sub/mul, range-checked result.
// Define CALC_ECHO_EN to echo the operand being entered on result.
module calc_engine
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned W      = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         overflow,
  output logic         busy
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic signed [2*W-1:0] MAXV = (2*W)'(10**DIGITS - 1);

  state_e                 state_q, state_d;
  op_e                    opr_q, opr_d;
  logic [W-1:0]           op1_q, op1_d, op2_q, op2_d;
  logic                   neg1_q, neg1_d, neg2_q, neg2_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [2*W-1:0]  val_q, val_d;
  logic                   mpend_q, mpend_d, ld_q, ld_d;
  logic [W-1:0]           result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   overflow_q, overflow_d, busy_q, busy_d;

  logic                   is_digit, is_sign, is_oper, in_range;
  logic [W-1:0]           digit_w, s1, s2;
  logic [W:0]             sum_c;
  logic                   mul_start_c, mul_abort_c, mul_done;
  logic [2*W-1:0]         mul_prod;

  assign is_digit = (key_code <= 4'd9);
  assign is_sign  = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);
  assign is_oper  = is_sign || (key_code == KEY_TIMES);
  assign digit_w  = W'(key_code);
  assign s1       = neg1_q ? -op1_q : op1_q;
  assign s2       = neg2_q ? -op2_q : op2_q;
  assign sum_c    = (opr_q == OP_SUB) ? ({s1[W-1], s1} - {s2[W-1], s2})
                                      : ({s1[W-1], s1} + {s2[W-1], s2});
  assign in_range = (val_q <= MAXV) && (val_q >= -MAXV);

  seq_mult #(.W(W)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .abort (mul_abort_c),
    .start (mul_start_c),
    .a     (s1),
    .b     (s2),
    .prod  (mul_prod),
    .done  (mul_done)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d        = state_q;
    opr_d          = opr_q;
    op1_d          = op1_q;
    op2_d          = op2_q;
    neg1_d         = neg1_q;
    neg2_d         = neg2_q;
    cnt_d          = cnt_q;
    val_d          = val_q;
    mpend_d        = 1'b0;
    ld_d           = mpend_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    overflow_d     = overflow_q;
    mul_start_c    = 1'b0;
    mul_abort_c    = 1'b0;

    if (ld_q) begin
      result_d       = in_range ? W'(val_q) : '0;
      overflow_d     = ~in_range;
      result_valid_d = 1'b1;
    end

    case (state_q)
      ST_SIGN1, ST_DONE: begin
        if (key_valid && (is_digit || is_sign)) begin
          op2_d      = '0;
          neg2_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = ST_DIG1;
          if (is_digit) begin
            op1_d  = digit_w;
            neg1_d = 1'b0;
            cnt_d  = CW'(1);
          end else begin
            op1_d  = '0;
            neg1_d = (key_code == KEY_MINUS);
            cnt_d  = '0;
          end
        end
      end
      ST_DIG1: begin
        if (key_valid) begin
          if (is_digit) begin
            if (cnt_q < CW'(DIGITS)) begin
              op1_d = op1_q * W'(10) + digit_w;
              cnt_d = cnt_q + CW'(1);
            end
          end else if (is_oper) begin
            opr_d   = key_to_op(key_code);
            cnt_d   = '0;
            state_d = ST_SIGN2;
          end else if (key_code == KEY_ENTER) begin
            state_d = ST_OP;
          end
        end
      end
      ST_OP: begin
        if (key_valid && is_oper) begin
          opr_d   = key_to_op(key_code);
          state_d = ST_SIGN2;
        end
      end
      ST_SIGN2: begin
        if (key_valid) begin
          if (is_sign) begin
            neg2_d  = (key_code == KEY_MINUS);
            state_d = ST_DIG2;
          end else if (is_digit) begin
            op2_d   = digit_w;
            cnt_d   = CW'(1);
            state_d = ST_DIG2;
          end else if (key_code == KEY_ENTER) begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_DIG2: begin
        if (key_valid) begin
          if (is_digit) begin
            if (cnt_q < CW'(DIGITS)) begin
              op2_d = op2_q * W'(10) + digit_w;
              cnt_d = cnt_q + CW'(1);
            end
          end else if (key_code == KEY_ENTER) begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (opr_q == OP_MUL) begin
          mul_start_c = 1'b1;
          state_d     = ST_MUL;
        end else begin
          val_d   = {{(W-1){sum_c[W]}}, sum_c};
          ld_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_MUL: begin
        // Product gets an extra register stage before its range check.
        if (mul_done) begin
          val_d   = mul_prod;
          mpend_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: ;
    endcase

    if (key_valid && (key_code == KEY_CLEAR)) begin
      state_d        = ST_SIGN1;
      opr_d          = OP_ADD;
      op1_d          = '0;
      op2_d          = '0;
      neg1_d         = 1'b0;
      neg2_d         = 1'b0;
      cnt_d          = '0;
      mpend_d        = 1'b0;
      ld_d           = 1'b0;
      mul_start_c    = 1'b0;
      mul_abort_c    = 1'b1;
      result_d       = result_q;
      result_valid_d = 1'b0;
      overflow_d     = 1'b0;
    end

`ifdef CALC_ECHO_EN
    if (key_valid && (key_code != KEY_CLEAR)) begin
      if ((state_d == ST_SIGN1) || (state_d == ST_DIG1))
        result_d = neg1_d ? -op1_d : op1_d;
      else if ((state_d == ST_SIGN2) || (state_d == ST_DIG2))
        result_d = neg2_d ? -op2_d : op2_d;
    end
`endif

    busy_d = (state_d == ST_EXEC) || (state_d == ST_MUL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_SIGN1;
      opr_q          <= OP_ADD;
      op1_q          <= '0;
      op2_q          <= '0;
      neg1_q         <= 1'b0;
      neg2_q         <= 1'b0;
      cnt_q          <= '0;
      val_q          <= '0;
      mpend_q        <= 1'b0;
      ld_q           <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      opr_q          <= opr_d;
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      neg1_q         <= neg1_d;
      neg2_q         <= neg2_d;
      cnt_q          <= cnt_d;
      val_q          <= val_d;
      mpend_q        <= mpend_d;
      ld_q           <= ld_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      busy_q         <= busy_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed self-checking bench for calc_engine (DIGITS=3, W=11).
module tb_calc_engine;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [10:0] result;
  logic        result_valid;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  calc_engine #(.DIGITS(3), .W(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a rising edge; returns just after the edge that accepted the key.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic press_seq(input logic [3:0] ks[$]);
    foreach (ks[i]) press(ks[i]);
  endtask

  // Cycles until result_valid is seen (0 = now), or -1 if the budget expires.
  task automatic wait_rv(input int max, output int lat);
    lat = -1;
    for (int i = 0; i <= max; i++) begin
      if (result_valid === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (result !== 11'd0) begin failures++; $display("FAIL reset_result: got %0d expected 0", result); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_rv: got %b expected 0", result_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_add;
    int lat;
    press_seq('{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd14});
    wait_rv(6, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency: got %0d expected 2", lat); end
    checks++; if ($signed(result) !== 579) begin failures++; $display("FAIL add_result: got %0d expected 579", $signed(result)); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL add_ovf: got %b expected 0", overflow); end
    @(posedge clk); #1;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL add_rv_pulse: got %b expected 0", result_valid); end
    checks++; if ($signed(result) !== 579) begin failures++; $display("FAIL add_hold: got %0d expected 579", $signed(result)); end
  endtask

  task automatic test_mul;
    int bcnt = 0, rvcnt = 0, rv_at = -1;
    press_seq('{4'd11, 4'd1, 4'd2, 4'd12, 4'd3, 4'd0, 4'd14});
    for (int i = 0; i <= 20; i++) begin
      if (busy === 1'b1) bcnt++;
      if (result_valid === 1'b1) begin
        rvcnt++;
        if (rv_at < 0) rv_at = i;
      end
      @(posedge clk); #1;
    end
    checks++; if (bcnt !== 12) begin failures++; $display("FAIL mul_busy_cycles: got %0d expected 12", bcnt); end
    checks++; if (rvcnt !== 1) begin failures++; $display("FAIL mul_rv_count: got %0d expected 1", rvcnt); end
    checks++; if (rv_at !== 14) begin failures++; $display("FAIL mul_latency: got %0d expected 14", rv_at); end
    checks++; if ($signed(result) !== -360) begin failures++; $display("FAIL mul_result: got %0d expected -360", $signed(result)); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mul_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow;
    int lat;
    press_seq('{4'd9, 4'd9, 4'd9, 4'd10, 4'd9, 4'd9, 4'd9, 4'd14});
    wait_rv(6, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL ovf_latency: got %0d expected 2", lat); end
    checks++; if (result !== 11'd0) begin failures++; $display("FAIL ovf_result: got %0d expected 0", $signed(result)); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    press(4'd5);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_on_key: got %b expected 0", overflow); end
`ifndef CALC_ECHO_EN
    checks++; if (result !== 11'd0) begin failures++; $display("FAIL ovf_result_hold: got %0d expected 0", $signed(result)); end
`endif
    press(4'd15);
  endtask

  task automatic test_digit_limit;
    int lat;
    press_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd11, 4'd2, 4'd3, 4'd14});
    wait_rv(6, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL limit_latency: got %0d expected 2", lat); end
    checks++; if ($signed(result) !== 146) begin failures++; $display("FAIL limit_result: got %0d expected 146", $signed(result)); end
    press_seq('{4'd5, 4'd0, 4'd12, 4'd2, 4'd0, 4'd14});
    wait_rv(20, lat);
    checks++; if (lat !== 14) begin failures++; $display("FAIL mulovf_latency: got %0d expected 14", lat); end
    checks++; if (result !== 11'd0) begin failures++; $display("FAIL mulovf_result: got %0d expected 0", $signed(result)); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL mulovf_flag: got %b expected 1", overflow); end
  endtask

  task automatic test_clear_mul;
    int lat, rvc = 0;
    press(4'd15);
    press_seq('{4'd2, 4'd10, 4'd3, 4'd14});
    wait_rv(6, lat);
    checks++; if ($signed(result) !== 5) begin failures++; $display("FAIL pre_clear_result: got %0d expected 5", $signed(result)); end
    press_seq('{4'd7, 4'd12, 4'd8, 4'd14});
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy_before: got %b expected 1", busy); end
    press(4'd15);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy_after: got %b expected 0", busy); end
    for (int i = 0; i < 20; i++) begin
      if (result_valid === 1'b1) rvc++;
      @(posedge clk); #1;
    end
    checks++; if (rvc !== 0) begin failures++; $display("FAIL clear_no_rv: got %0d expected 0", rvc); end
    checks++; if ($signed(result) !== 5) begin failures++; $display("FAIL clear_hold: got %0d expected 5", $signed(result)); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_ovf: got %b expected 0", overflow); end
    press_seq('{4'd2, 4'd12, 4'd3, 4'd14});
    wait_rv(20, lat);
    checks++; if (lat !== 14) begin failures++; $display("FAIL after_abort_latency: got %0d expected 14", lat); end
    checks++; if ($signed(result) !== 6) begin failures++; $display("FAIL after_abort_result: got %0d expected 6", $signed(result)); end
  endtask

  task automatic test_reset_mid;
    int lat;
    press_seq('{4'd4, 4'd10, 4'd5});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (result !== 11'd0) begin failures++; $display("FAIL rstmid_result: got %0d expected 0", $signed(result)); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL rstmid_rv: got %b expected 0", result_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rstmid_ovf: got %b expected 0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    press(4'd14);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_enter_ignored: got %b expected 0", busy); end
    press_seq('{4'd3, 4'd10, 4'd4, 4'd14});
    wait_rv(6, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rstmid_latency: got %0d expected 2", lat); end
    checks++; if ($signed(result) !== 7) begin failures++; $display("FAIL rstmid_result2: got %0d expected 7", $signed(result)); end
  endtask

  task automatic test_back_to_back;
    int lat;
    press_seq('{4'd1, 4'd13, 4'd11, 4'd9, 4'd14});
    wait_rv(6, lat);
    checks++; if ($signed(result) !== -8) begin failures++; $display("FAIL b2b_sub: got %0d expected -8", $signed(result)); end
    press_seq('{4'd8, 4'd10, 4'd14});
    wait_rv(6, lat);
    checks++; if ($signed(result) !== 8) begin failures++; $display("FAIL sign2_enter: got %0d expected 8", $signed(result)); end
    press_seq('{4'd6, 4'd14, 4'd13, 4'd12, 4'd7, 4'd14});
    wait_rv(20, lat);
    checks++; if (lat !== 14) begin failures++; $display("FAIL op_state_latency: got %0d expected 14", lat); end
    checks++; if ($signed(result) !== 42) begin failures++; $display("FAIL op_state_mul: got %0d expected 42", $signed(result)); end
    press_seq('{4'd11, 4'd9, 4'd9, 4'd9, 4'd10, 4'd14});
    wait_rv(6, lat);
    checks++; if ($signed(result) !== -999 || overflow !== 1'b0) begin failures++; $display("FAIL min_in_range: got %0d ovf %b expected -999 ovf 0", $signed(result), overflow); end
    press_seq('{4'd11, 4'd9, 4'd9, 4'd9, 4'd11, 4'd1, 4'd14});
    wait_rv(6, lat);
    checks++; if (result !== 11'd0 || overflow !== 1'b1) begin failures++; $display("FAIL below_min: got %0d ovf %b expected 0 ovf 1", $signed(result), overflow); end
    press_seq('{4'd2, 4'd12, 4'd2, 4'd14, 4'd5, 4'd14});
    wait_rv(20, lat);
    checks++; if (lat !== 12) begin failures++; $display("FAIL busy_drop_latency: got %0d expected 12", lat); end
    checks++; if ($signed(result) !== 4) begin failures++; $display("FAIL busy_drop_result: got %0d expected 4", $signed(result)); end
  endtask

`ifdef CALC_ECHO_EN
  task automatic test_echo;
    press(4'd15);
    press(4'd11);
    press(4'd4);
    checks++; if ($signed(result) !== -4 || result_valid !== 1'b0) begin failures++; $display("FAIL echo_first: got %0d rv %b expected -4 rv 0", $signed(result), result_valid); end
    press(4'd2);
    checks++; if ($signed(result) !== -42 || result_valid !== 1'b0) begin failures++; $display("FAIL echo_second: got %0d rv %b expected -42 rv 0", $signed(result), result_valid); end
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_mul;
    test_overflow;
    test_digit_limit;
    test_clear_mul;
    test_reset_mid;
    test_back_to_back;
`ifdef CALC_ECHO_EN
    test_echo;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
